// File: rtl/mem_mmio_responder_if.sv
// Host loader port and control-unit port of the image RAM / MMIO responder.
interface mem_mmio_responder_if;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_err;
  logic        cu_we;
  logic [15:0] cu_addr;
  logic [7:0]  cu_wdata;
  logic [7:0]  cu_rdata;
  logic        cu_busy;
  logic        cu_done;

  modport master (
    output host_we, host_addr, host_wdata,
    output cu_we, cu_addr, cu_wdata, cu_busy, cu_done,
    input  host_rdata, host_err, cu_rdata
  );

  modport slave (
    input  host_we, host_addr, host_wdata,
    input  cu_we, cu_addr, cu_wdata, cu_busy, cu_done,
    output host_rdata, host_err, cu_rdata
  );
endinterface

// File: rtl/mem_mmio_responder.sv
// Image RAM plus MMIO register window 0xFFF0-0xFFFF for the downscaler control unit.
// The CU owns the RAM while cu_busy is high; otherwise the host loader does.
module mem_mmio_responder #(
  parameter int unsigned RAM_DEPTH  = 32768,
  parameter logic [15:0] DEF_WIDTH  = 16'd64,
  parameter logic [15:0] DEF_HEIGHT = 16'd64,
  parameter logic [15:0] DEF_SCALE  = 16'h0080,
  parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  mem_mmio_responder_if.slave   bus,
  output logic [15:0]           cfg_width,
  output logic [15:0]           cfg_height,
  output logic [15:0]           cfg_scale,
  output logic [7:0]            cfg_mode,
  output logic                  start_proc,
  output logic                  step_mode,
  output logic                  step_pulse
);

  localparam int unsigned AW     = $clog2(RAM_DEPTH);
  localparam int unsigned N_CNT  = 6;

  logic [7:0] mem [RAM_DEPTH];
  logic [7:0] cnt [N_CNT];
  logic       done_q;

  logic       host_is_ram_c, host_is_mmio_c, cu_is_ram_c, cu_is_mmio_c;
  logic [3:0] host_reg_c, cu_reg_c;
  logic       host_ram_we_c, host_cfg_we_c, host_f7_we_c, host_rej_c;
  logic       cu_ram_we_c, cu_cnt_we_c, done_rise_c;
  logic [7:0] host_rd_c, cu_rd_c;

  assign host_is_ram_c  = (32'(bus.host_addr) < RAM_DEPTH);
  assign host_is_mmio_c = (bus.host_addr[15:4] == 12'hFFF);
  assign host_reg_c     = bus.host_addr[3:0];
  assign cu_is_ram_c    = (32'(bus.cu_addr) < RAM_DEPTH);
  assign cu_is_mmio_c   = (bus.cu_addr[15:4] == 12'hFFF);
  assign cu_reg_c       = bus.cu_addr[3:0];
  assign done_rise_c    = bus.cu_done & ~done_q;

  // Register window read mux shared by both ports.
  function automatic logic [7:0] mmio_rd(input logic [3:0] r);
    logic [7:0] d;
    d = 8'h00;
    case (r)
      4'h0: d = cfg_width[7:0];
      4'h1: d = cfg_width[15:8];
      4'h2: d = cfg_height[7:0];
      4'h3: d = cfg_height[15:8];
      4'h4: d = cfg_scale[7:0];
      4'h5: d = cfg_scale[15:8];
      4'h6: d = cfg_mode;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: d = cnt[3'(r - 4'h8)];
      4'hE: d = {6'd0, bus.cu_done, bus.cu_busy};
      4'hF: d = ID_VALUE;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // Host access decode: while the CU runs only MMIO reads and step control get through.
  always_comb begin
    host_ram_we_c = 1'b0;
    host_cfg_we_c = 1'b0;
    host_f7_we_c  = 1'b0;
    host_rej_c    = 1'b0;
    if (bus.host_we && host_is_mmio_c && host_reg_c == 4'h7) host_f7_we_c = 1'b1;
    if (bus.cu_busy) begin
      if (bus.host_we) host_rej_c = ~host_f7_we_c;
      else if (host_is_ram_c) host_rej_c = 1'b1;
    end else if (bus.host_we) begin
      if (host_is_ram_c) host_ram_we_c = 1'b1;
      else if (host_is_mmio_c) begin
        if (host_reg_c <= 4'h7) host_cfg_we_c = 1'b1;
        else if (host_reg_c <= 4'hD) host_rej_c = 1'b1;
      end
    end
  end

  // CU writes only land while it holds the bus.
  always_comb begin
    cu_ram_we_c = bus.cu_busy & bus.cu_we & cu_is_ram_c;
    cu_cnt_we_c = bus.cu_busy & bus.cu_we & cu_is_mmio_c &
                  (cu_reg_c >= 4'h8) & (cu_reg_c <= 4'hD);
  end

  always_comb begin
    host_rd_c = 8'h00;
    if (host_rej_c) host_rd_c = 8'h00;
    else if (host_is_ram_c) host_rd_c = mem[bus.host_addr[AW-1:0]];
    else if (host_is_mmio_c) host_rd_c = mmio_rd(host_reg_c);
  end

  always_comb begin
    cu_rd_c = 8'h00;
    if (cu_is_ram_c) cu_rd_c = mem[bus.cu_addr[AW-1:0]];
    else if (cu_is_mmio_c) cu_rd_c = mmio_rd(cu_reg_c);
  end

  // Single RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (cu_ram_we_c) mem[bus.cu_addr[AW-1:0]] <= bus.cu_wdata;
    else if (host_ram_we_c) mem[bus.host_addr[AW-1:0]] <= bus.host_wdata;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cfg_width      <= DEF_WIDTH;
      cfg_height     <= DEF_HEIGHT;
      cfg_scale      <= DEF_SCALE;
      cfg_mode       <= 8'h00;
      start_proc     <= 1'b0;
      step_mode      <= 1'b0;
      step_pulse     <= 1'b0;
      done_q         <= 1'b0;
      bus.host_rdata <= 8'h00;
      bus.host_err   <= 1'b0;
      bus.cu_rdata   <= 8'h00;
      for (int i = 0; i < int'(N_CNT); i++) cnt[i] <= 8'h00;
    end else begin
      done_q         <= bus.cu_done;
      step_pulse     <= 1'b0;
      bus.host_rdata <= host_rd_c;
      bus.host_err   <= host_rej_c;
      bus.cu_rdata   <= cu_rd_c;
      if (host_cfg_we_c) begin
        case (host_reg_c)
          4'h0: cfg_width[7:0]   <= bus.host_wdata;
          4'h1: cfg_width[15:8]  <= bus.host_wdata;
          4'h2: cfg_height[7:0]  <= bus.host_wdata;
          4'h3: cfg_height[15:8] <= bus.host_wdata;
          4'h4: cfg_scale[7:0]   <= bus.host_wdata;
          4'h5: cfg_scale[15:8]  <= bus.host_wdata;
          4'h6: cfg_mode         <= bus.host_wdata;
          default: ;
        endcase
      end
      if (host_f7_we_c) begin
        step_mode  <= bus.host_wdata[1];
        step_pulse <= bus.host_wdata[2];
      end
      // Completion clears start even if the host sets it in the same cycle.
      if (done_rise_c) start_proc <= 1'b0;
      else if (host_cfg_we_c && host_reg_c == 4'h7) start_proc <= bus.host_wdata[0];
      if (cu_cnt_we_c) cnt[3'(cu_reg_c - 4'h8)] <= bus.cu_wdata;
    end
  end

endmodule

// File: tb/tb_mem_mmio_responder.sv
// Directed bench for mem_mmio_responder with a read-data scoreboard per port.
module tb_mem_mmio_responder;
  logic        clk = 1'b0;
  logic        aclr_n;
  logic [15:0] cfg_width, cfg_height, cfg_scale;
  logic [7:0]  cfg_mode;
  logic        start_proc, step_mode, step_pulse;

  int total = 0;
  int bad   = 0;
  logic [8:0] hq[$];
  logic [7:0] cq[$];

  mem_mmio_responder_if bus();

  mem_mmio_responder dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .bus        (bus),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_scale  (cfg_scale),
    .cfg_mode   (cfg_mode),
    .start_proc (start_proc),
    .step_mode  (step_mode),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle on both ports; optional expected read results go through the scoreboard.
  task automatic cyc(input string tag,
                     input logic hwe, input logic [15:0] ha, input logic [7:0] hd,
                     input logic hchk, input logic hexp_err, input logic [7:0] hexp,
                     input logic cwe, input logic [15:0] ca, input logic [7:0] cd,
                     input logic cchk, input logic [7:0] cexp);
    logic [8:0] he;
    logic [7:0] ce;
    @(negedge clk);
    bus.host_we = hwe; bus.host_addr = ha; bus.host_wdata = hd;
    bus.cu_we = cwe;   bus.cu_addr = ca;   bus.cu_wdata = cd;
    if (hchk) hq.push_back({hexp_err, hexp});
    if (cchk) cq.push_back(cexp);
    @(posedge clk);
    #1;
    if (hchk) begin
      he = hq.pop_front();
      chk({tag, "_host"}, {7'd0, bus.host_err, bus.host_rdata}, {7'd0, he});
    end
    if (cchk) begin
      ce = cq.pop_front();
      chk({tag, "_cu"}, {8'd0, bus.cu_rdata}, {8'd0, ce});
    end
  endtask

  task automatic hwr(input logic [15:0] a, input logic [7:0] d);
    cyc("hwr", 1'b1, a, d, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic hrd(input string tag, input logic [15:0] a, input logic e, input logic [7:0] d);
    cyc(tag, 1'b0, a, 8'h00, 1'b1, e, d, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic cwr(input logic [15:0] a, input logic [7:0] d);
    cyc("cwr", 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, a, d, 1'b0, 8'h00);
  endtask

  initial begin
    aclr_n = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = 16'hFFFF; bus.host_wdata = 8'h00;
    bus.cu_we = 1'b0;   bus.cu_addr = 16'h0000;   bus.cu_wdata = 8'h00;
    bus.cu_busy = 1'b0; bus.cu_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) aclr_n = 1'b1;
    #1;
    chk("rst_width", cfg_width, 16'd64);
    chk("rst_height", cfg_height, 16'd64);
    chk("rst_scale", cfg_scale, 16'h0080);
    chk("rst_mode", {8'd0, cfg_mode}, 16'h0000);
    chk("rst_start", {15'd0, start_proc}, 16'h0000);
    chk("rst_step", {14'd0, step_mode, step_pulse}, 16'h0000);
    chk("rst_err", {15'd0, bus.host_err}, 16'h0000);

    hrd("id", 16'hFFFF, 1'b0, 8'hA5);
    hwr(16'h0005, 8'h12);
    hrd("ram5", 16'h0005, 1'b0, 8'h12);
    hwr(16'h9000, 8'h77);
    hrd("unmap9000", 16'h9000, 1'b0, 8'h00);
    hwr(16'h7FFF, 8'h3C);
    hrd("ram_top", 16'h7FFF, 1'b0, 8'h3C);
    hrd("unmap8000", 16'h8000, 1'b0, 8'h00);

    hwr(16'hFFF0, 8'h20);
    hwr(16'hFFF1, 8'h01);
    chk("cfg_width_wr", cfg_width, 16'h0120);
    hrd("rd_f0", 16'hFFF0, 1'b0, 8'h20);
    hwr(16'hFFF6, 8'h01);
    chk("cfg_mode_wr", {8'd0, cfg_mode}, 16'h0001);
    cyc("host_wr_cnt", 1'b1, 16'hFFF8, 8'h99, 1'b1, 1'b1, 8'h00,
        1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    hrd("cnt_untouched", 16'hFFF8, 1'b0, 8'h00);
    hwr(16'hFFF7, 8'h01);
    chk("start_set", {15'd0, start_proc}, 16'h0001);
    hrd("rd_f7", 16'hFFF7, 1'b0, 8'h00);
    hwr(16'h4000, 8'hAA);

    bus.cu_busy = 1'b1;
    hrd("mmio_rd_busy", 16'hFFFF, 1'b0, 8'hA5);
    cwr(16'hFFF8, 8'h40);
    cwr(16'hFFF9, 8'h00);
    cwr(16'hFFF0, 8'h99);
    chk("cu_cfg_ignored", cfg_width, 16'h0120);
    cyc("rw_same", 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 8'h00,
        1'b1, 16'h4000, 8'h55, 1'b1, 8'hAA);
    cyc("rw_next", 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 8'h00,
        1'b0, 16'h4000, 8'h00, 1'b1, 8'h55);
    cyc("busy_cfg_wr", 1'b1, 16'hFFF0, 8'h11, 1'b1, 1'b1, 8'h00,
        1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("busy_cfg_kept", cfg_width, 16'h0120);
    hrd("err_one_cycle", 16'hFFFF, 1'b0, 8'hA5);
    hrd("busy_ram_rd", 16'h0005, 1'b1, 8'h00);
    cyc("busy_step", 1'b1, 16'hFFF7, 8'h06, 1'b1, 1'b0, 8'h00,
        1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    chk("step_on", {14'd0, step_mode, step_pulse}, 16'h0003);
    hrd("idle_after_step", 16'hFFFF, 1'b0, 8'hA5);
    chk("step_pulse_low", {14'd0, step_mode, step_pulse}, 16'h0002);
    chk("start_kept_busy", {15'd0, start_proc}, 16'h0001);

    bus.cu_busy = 1'b0;
    bus.cu_done = 1'b1;
    hrd("done_idle", 16'hFFFF, 1'b0, 8'hA5);
    hrd("done_idle2", 16'hFFFF, 1'b0, 8'hA5);
    chk("start_cleared", {15'd0, start_proc}, 16'h0000);
    hrd("rd_f8", 16'hFFF8, 1'b0, 8'h40);
    hrd("rd_f9", 16'hFFF9, 1'b0, 8'h00);
    hrd("rd_fe", 16'hFFFE, 1'b0, 8'h02);
    cwr(16'hFFF8, 8'h77);
    cwr(16'h4000, 8'h11);
    hrd("cu_wr_idle_cnt", 16'hFFF8, 1'b0, 8'h40);
    hrd("cu_wr_idle_ram", 16'h4000, 1'b0, 8'h55);

    bus.cu_done = 1'b0;
    hrd("done_low", 16'hFFFF, 1'b0, 8'hA5);
    bus.cu_done = 1'b1;
    hwr(16'hFFF7, 8'h01);
    chk("hw_clear_wins", {15'd0, start_proc}, 16'h0000);

    bus.cu_done = 1'b0;
    hrd("done_low2", 16'hFFFF, 1'b0, 8'hA5);
    hwr(16'hFFF7, 8'h01);
    chk("start_again", {15'd0, start_proc}, 16'h0001);
    hwr(16'hFFF0, 8'h33);
    #2 aclr_n = 1'b0;
    #1;
    chk("mid_rst_start", {15'd0, start_proc}, 16'h0000);
    chk("mid_rst_width", cfg_width, 16'd64);
    chk("mid_rst_mode", {8'd0, cfg_mode}, 16'h0000);
    chk("mid_rst_stepmode", {15'd0, step_mode}, 16'h0000);
    @(negedge clk) aclr_n = 1'b1;
    hrd("cnt_after_rst", 16'hFFF8, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
